// File: rtl/counter_rr_scheduler.sv
// Round-robin scheduler sharing one loadable up-counter among NUM_REQ requesters.
// Each granted requester gets one run: the counter is loaded with its start value,
// enabled until it reaches all ones, then done pulses on the owner's bit.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   req           : level request per requester (drop to abort)
//   req_start     : per-requester start value, slice i = [i*WIDTH +: WIDTH]
//   grant         : one-hot owner of the counter, zero when idle
//   done          : one-cycle pulse on the owner's bit when its run completes
//   busy          : high whenever not idle
//   cnt_load      : counter load strobe
//   cnt_enable    : counter enable (combinational decode of cnt_value in RUN)
//   cnt_data      : counter load data (owner's start value)
//   cnt_value     : counter's current count
module counter_rr_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_start,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic                     cnt_load,
  output logic                     cnt_enable,
  output logic [WIDTH-1:0]         cnt_data,
  input  logic [WIDTH-1:0]         cnt_value
);

  localparam int unsigned      IDX_W    = $clog2(NUM_REQ);
  localparam logic [WIDTH-1:0] MAX      = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 load_q, load_d;
  logic                 busy_q, busy_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;

  logic                 found_c;
  logic [IDX_W-1:0]     win_c;
  logic [IDX_W-1:0]     cand_c;
  logic [IDX_W-1:0]     next_ptr_c;
  logic                 cnt_at_max_c;
  logic [WIDTH-1:0]     start_arr [NUM_REQ];

  // Unpack the flat start-value bus into one entry per requester.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_start
    assign start_arr[i] = req_start[i*WIDTH +: WIDTH];
  end

  // First requesting index at or after ptr, wrapping around.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    cand_c  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_c = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!found_c && req[cand_c]) begin
        found_c = 1'b1;
        win_c   = cand_c;
      end
    end
  end

  // The finishing or aborting owner becomes lowest priority.
  assign next_ptr_c   = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
  assign cnt_at_max_c = (cnt_value == MAX);

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    data_d  = data_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    done_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (found_c) begin
          state_d = S_LOAD;
          grant_d = NUM_REQ'(1) << win_c;
          data_d  = start_arr[win_c];
          owner_d = win_c;
        end
      end
      S_LOAD: begin
        if (!req[owner_q]) begin
          state_d = S_IDLE;
          grant_d = '0;
          ptr_d   = next_ptr_c;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // A dropped request wins over completion in the same cycle.
        if (!req[owner_q]) begin
          state_d = S_IDLE;
          grant_d = '0;
          ptr_d   = next_ptr_c;
        end else if (cnt_at_max_c) begin
          state_d = S_DONE;
          done_d  = grant_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        ptr_d   = next_ptr_c;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
    load_d = (state_d == S_LOAD);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Enable stops the counter at MAX so it never wraps.
  assign cnt_enable = (state_q == S_RUN) && !cnt_at_max_c;

  assign grant    = grant_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign cnt_load = load_q;
  assign cnt_data = data_q;

endmodule

// File: tb/tb_counter_rr_scheduler.sv
// Testbench for counter_rr_scheduler: directed scenarios plus randomized
// transactions, checked against a transaction-level round-robin model and a
// simple behavioural counter driven by the scheduler's load/enable/data.
module tb_counter_rr_scheduler;

  localparam int unsigned NR   = 4;
  localparam int unsigned W    = 4;
  localparam int unsigned SW   = NR * W;
  localparam logic [W-1:0] MAXV = '1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req;
  logic [SW-1:0] req_start;
  logic [NR-1:0] grant;
  logic [NR-1:0] done;
  logic          busy;
  logic          cnt_load;
  logic          cnt_enable;
  logic [W-1:0]  cnt_data;
  logic [W-1:0]  cnt_value;
  logic [W-1:0]  cnt_q = '0;

  int n_cmp = 0;
  int n_err = 0;
  int ptr_m = 0;

  counter_rr_scheduler #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_start (req_start),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .cnt_load  (cnt_load),
    .cnt_enable(cnt_enable),
    .cnt_data  (cnt_data),
    .cnt_value (cnt_value)
  );

  always #5 clk = ~clk;

  // The shared loadable up-counter.
  always @(posedge clk) begin
    if (cnt_load)        cnt_q <= cnt_data;
    else if (cnt_enable) cnt_q <= cnt_q + 1'b1;
  end
  assign cnt_value = cnt_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_grant"},  32'(grant), 32'd0);
    chk({tag, "_done"},   32'(done), 32'd0);
    chk({tag, "_busy"},   32'(busy), 32'd0);
    chk({tag, "_load"},   32'(cnt_load), 32'd0);
    chk({tag, "_enable"}, 32'(cnt_enable), 32'd0);
  endtask

  // Round-robin choice: first set bit scanning up from the model pointer.
  function automatic int pick(input logic [NR-1:0] m);
    for (int i = 0; i < int'(NR); i++) begin
      int idx;
      idx = (ptr_m + i) % int'(NR);
      if (m[idx]) return idx;
    end
    return 0;
  endfunction

  // Called at a falling edge with the scheduler idle; leaves at the falling edge
  // of the next idle cycle. abort_at: 0 none, >0 drop owner's req in that cycle,
  // <0 pick a random abort cycle within LOAD/RUN.
  task automatic run_txn(input logic [NR-1:0] mask, input logic [SW-1:0] starts,
                         input int abort_at, input bit jitter);
    int           w, len, last, ab;
    logic [W-1:0] s;
    logic [NR-1:0] oh;
    check_idle("idle");
    req       = mask;
    req_start = starts;
    w    = pick(mask);
    s    = starts[w*W +: W];
    len  = int'(MAXV) - int'(s);
    ab   = abort_at;
    if (ab < 0) ab = int'($urandom_range(32'(1 + len), 32'd1));
    last = (ab > 0) ? ab : 3 + len;
    oh    = '0;
    oh[w] = 1'b1;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      chk("grant", 32'(grant), 32'(oh));
      chk("busy", 32'(busy), 32'd1);
      chk("cnt_load", 32'(cnt_load), (k == 1) ? 32'd1 : 32'd0);
      chk("cnt_enable", 32'(cnt_enable), (k >= 2 && k <= 1 + len) ? 32'd1 : 32'd0);
      chk("done", 32'(done), (k == 3 + len) ? 32'(oh) : 32'd0);
      chk("cnt_data", 32'(cnt_data), 32'(s));
      if (k >= 2 && k <= 2 + len) chk("cnt_value", 32'(cnt_value), 32'(s) + 32'(k - 2));
      chk("load_and_enable", 32'(cnt_load & cnt_enable), 32'd0);
      chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      if (jitter) begin
        req       = NR'($urandom);
        req[w]    = 1'b1;
        req_start = SW'($urandom);
      end
      if (k == ab) req[w] = 1'b0;
    end
    ptr_m = (w + 1) % int'(NR);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    chk("reset_cnt_data", 32'(cnt_data), 32'd0);
    rst   = 1'b0;
    ptr_m = 0;
  endtask

  initial begin
    int           gap;
    int           ab;
    logic [NR-1:0] mask;
    req       = '0;
    req_start = '0;
    @(negedge clk);

    // Single request from 0xC.
    do_reset();
    run_txn(4'b0001, 16'h000C, 0, 1'b0);

    // Start at MAX: no enable cycles, done three cycles after request.
    do_reset();
    run_txn(4'b0100, 16'h0F00, 0, 1'b0);

    // All requesting: rotation 0,1,2,3,0.
    do_reset();
    repeat (5) run_txn(4'b1111, 16'hEEEE, 0, 1'b0);

    // Abort requester 1 mid-run while 3 waits, then 3 gets the counter.
    do_reset();
    run_txn(4'b1010, 16'h0000, 6, 1'b0);
    run_txn(4'b1000, 16'h0000, 0, 1'b0);

    // Reset during RUN, then requesters 0 and 2.
    req       = 4'b0001;
    req_start = '0;
    repeat (3) @(negedge clk);
    chk("midrun_busy", 32'(busy), 32'd1);
    do_reset();
    run_txn(4'b0101, 16'h0E0E, 0, 1'b0);
    run_txn(4'b0101, 16'h0E0E, 0, 1'b0);

    // Fairness between 0 and 3 both held.
    do_reset();
    repeat (4) run_txn(4'b1001, 16'hD00D, 0, 1'b0);

    // Randomized transactions with idle gaps, aborts and input jitter.
    repeat (60) begin
      gap = int'($urandom_range(2, 0));
      repeat (gap) begin
        check_idle("gap");
        req = '0;
        @(negedge clk);
      end
      mask = NR'($urandom_range(15, 1));
      ab   = ($urandom_range(3, 0) == 0) ? -1 : 0;
      run_txn(mask, SW'($urandom), ab, 1'b1);
    end

    check_idle("end");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
